key_conditioner: RTL

Multi-channel front end for the player's push-buttons and switches. Each channel synchronises an asynchronous input, debounces it, and produces a clean level, one-cycle edge pulses (rising, falling or both), and an optional hold-to-repeat pulse train. It sits between the board pins and the player control FSM, and replaces the single-channel two-flop edge detector.

---
 rtl/key_conditioner.sv | 62 ++++++
 1 files changed

// File: rtl/key_conditioner.sv
// key_conditioner: per-channel synchroniser, debouncer, edge pulse and hold-to-repeat generator.
module key_conditioner #(
    parameter int CHANNELS        = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int EDGE_MODE       = 0,
    parameter int REPEAT_DELAY    = 0,
    parameter int REPEAT_PERIOD   = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] key_in,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] key_pulse,
    output logic [CHANNELS-1:0] rpt
);
    localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RMAX = REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);
    localparam logic [DW-1:0] DB_T = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] RD_T = RW'(REPEAT_DELAY > 0 ? REPEAT_DELAY - 1 : 0);
    localparam logic [RW-1:0] RP_T = RW'(REPEAT_PERIOD - 1);
    localparam bit REP_EN = REPEAT_DELAY > 0;

    logic [SYNC_STAGES-1:0][CHANNELS-1:0] sync;
    logic [CHANNELS-1:0] s;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) sync <= '0;
        else sync <= {sync[SYNC_STAGES-2:0], key_in};

    assign s = sync[SYNC_STAGES-1];

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic [DW-1:0] dcnt;
        logic [RW-1:0] rcnt;
        logic first, lvl, kp, rp, chg, nxt, hit;
        assign chg = (s[g] != lvl) && (dcnt == DB_T);
        assign nxt = chg ? s[g] : lvl;
        assign hit = first ? (rcnt == RD_T) : (rcnt == RP_T);
        // repeat logic only runs while level is 1 both before and after this edge
        always_ff @(posedge clk or negedge rst_n)
            if (!rst_n) begin
                dcnt  <= '0;
                rcnt  <= '0;
                first <= 1'b0;
                lvl   <= 1'b0;
                kp    <= 1'b0;
                rp    <= 1'b0;
            end else begin
                dcnt  <= (s[g] == lvl || chg) ? '0 : dcnt + 1'b1;
                lvl   <= nxt;
                kp    <= chg && (EDGE_MODE == 2 || s[g] == (EDGE_MODE == 0));
                rp    <= REP_EN && lvl && nxt && hit;
                rcnt  <= (!REP_EN || !lvl || !nxt || hit) ? '0 : rcnt + 1'b1;
                first <= REP_EN && nxt && (!lvl || (first && !hit));
            end
        assign level[g]     = lvl;
        assign key_pulse[g] = kp;
        assign rpt[g]       = rp;
    end
endmodule
